// File: rtl/studio2_pkg.sv
// Shared definitions for the Studio II RAM arbiter.
//   arb_state_t  : arbiter FSM states
//   IDX_BIOS/CART: ioctl_index values accepted by the loader
//   *_DEF        : default geometry for the Studio II memory map
package studio2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DMA,
        ST_CPU_RD,
        ST_CPU_WR
    } arb_state_t;

    localparam logic [7:0] IDX_BIOS = 8'd0;
    localparam logic [7:0] IDX_CART = 8'd1;

    localparam int ADDR_W_DEF    = 12;
    localparam int DMA_BURST_DEF = 8;
    localparam int CART_BASE_DEF = 'h400;

endpackage

// File: rtl/studio2_ram_arbiter.sv
// Single-port RAM arbiter for the Studio II memory map.
// One synchronous RAM (1-cycle read latency) is shared by the hps_io loader,
// the CDP1861 video DMA and the CDP1802 CPU.
// Ports:
//   clk, reset                      clock, async active-high reset
//   ioctl_download/index/wr/addr/dout  loader interface (index 0 BIOS, 1 cart)
//   cpu_req/we/addr/wdata -> cpu_ack/cpu_rdata   CPU access, one ack per access
//   dma_req/dma_addr -> dma_ack/dma_data/dma_done  video burst of DMA_BURST bytes
//   load_busy                       loader owns the RAM
//   ram_addr/we/wdata, ram_rdata    registered RAM port
module studio2_ram_arbiter
    import studio2_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DMA_BURST = DMA_BURST_DEF,
    parameter int CART_BASE = CART_BASE_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    output logic              dma_ack,
    output logic [7:0]        dma_data,
    output logic              dma_done,
    output logic              load_busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);

    localparam int CNT_W = $clog2(DMA_BURST + 1);

    arb_state_t        state;
    logic              pend;
    logic [ADDR_W-1:0] pend_addr;
    logic [7:0]        pend_data;
    logic [ADDR_W-1:0] dma_base;
    logic [CNT_W-1:0]  dma_cnt;    // addresses issued so far in this burst
    logic [1:0]        vld_pipe;   // [0]: address on ram_addr, [1]: its data on ram_rdata
    logic              rd_phase;   // CPU read: 0 = RAM latching address, 1 = data on ram_rdata
    logic [25:0]       load_tgt;
    logic              load_ok;

    // Loader target address; anything outside the RAM or with an unknown
    // index is silently dropped.
    always_comb begin
        load_tgt = {1'b0, ioctl_addr} + ((ioctl_index == IDX_CART) ? 26'(CART_BASE) : 26'd0);
        load_ok  = ioctl_wr
                && (ioctl_index == IDX_BIOS || ioctl_index == IDX_CART)
                && ((load_tgt >> ADDR_W) == 26'd0);
    end

    // One-entry pending write. A new strobe wins over the clear on grant;
    // hps_io spacing makes that collision impossible in practice.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend      <= 1'b0;
            pend_addr <= '0;
            pend_data <= '0;
            load_busy <= 1'b0;
        end else begin
            if (load_ok) begin
                pend      <= 1'b1;
                pend_addr <= load_tgt[ADDR_W-1:0];
                pend_data <= ioctl_dout;
            end else if (state == ST_IDLE && pend) begin
                pend <= 1'b0;
            end
            load_busy <= ioctl_download | pend | load_ok;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
            dma_ack   <= 1'b0;
            dma_data  <= '0;
            dma_done  <= 1'b0;
            dma_base  <= '0;
            dma_cnt   <= '0;
            vld_pipe  <= '0;
            rd_phase  <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            ram_we   <= 1'b0;
            cpu_ack  <= 1'b0;
            dma_ack  <= 1'b0;
            dma_done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (pend) begin
                        state     <= ST_LOAD;
                        ram_addr  <= pend_addr;
                        ram_wdata <= pend_data;
                        ram_we    <= 1'b1;
                    end else if (!ioctl_download && dma_req) begin
                        state    <= ST_DMA;
                        ram_addr <= dma_addr;
                        dma_base <= dma_addr;
                        dma_cnt  <= CNT_W'(1);
                        vld_pipe <= 2'b01;
                    end else if (!ioctl_download && cpu_req) begin
                        ram_addr <= cpu_addr;
                        if (cpu_we) begin
                            state     <= ST_CPU_WR;
                            ram_we    <= 1'b1;
                            ram_wdata <= cpu_wdata;
                        end else begin
                            state    <= ST_CPU_RD;
                            rd_phase <= 1'b0;
                        end
                    end
                end

                ST_LOAD: state <= ST_IDLE;

                ST_CPU_WR: begin
                    cpu_ack <= 1'b1;
                    state   <= ST_IDLE;
                end

                ST_CPU_RD: begin
                    if (!rd_phase) begin
                        rd_phase <= 1'b1;
                    end else begin
                        cpu_ack   <= 1'b1;
                        cpu_rdata <= ram_rdata;
                        state     <= ST_IDLE;
                    end
                end

                ST_DMA: begin
                    // Whatever read has already landed on ram_rdata is delivered.
                    dma_ack  <= vld_pipe[1];
                    dma_data <= ram_rdata;
                    if (ioctl_download) begin
                        // Abort: drop the rest of the burst, no dma_done.
                        vld_pipe <= '0;
                        state    <= ST_IDLE;
                    end else if (vld_pipe[1] && !vld_pipe[0]) begin
                        // Last byte of the burst is being delivered now.
                        dma_done <= 1'b1;
                        vld_pipe <= '0;
                        state    <= ST_IDLE;
                    end else begin
                        vld_pipe[1] <= vld_pipe[0];
                        if (dma_cnt != CNT_W'(DMA_BURST)) begin
                            // Address arithmetic wraps modulo the RAM size.
                            ram_addr    <= dma_base + ADDR_W'(dma_cnt);
                            dma_cnt     <= dma_cnt + 1'b1;
                            vld_pipe[0] <= 1'b1;
                        end else begin
                            vld_pipe[0] <= 1'b0;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_studio2_ram_arbiter.sv
// Self-checking bench for studio2_ram_arbiter: table-driven CPU accesses,
// queue scoreboards for CPU and DMA results, hand sequences for the
// loader, burst arbitration, download abort and asynchronous reset.
module tb_studio2_ram_arbiter;
    import studio2_pkg::*;

    localparam int AW    = 12;
    localparam int BURST = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ioctl_download = 1'b0;
    logic [7:0]    ioctl_index = '0;
    logic          ioctl_wr = 1'b0;
    logic [24:0]   ioctl_addr = '0;
    logic [7:0]    ioctl_dout = '0;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [7:0]    cpu_wdata = '0;
    logic          cpu_ack;
    logic [7:0]    cpu_rdata;
    logic          dma_req = 1'b0;
    logic [AW-1:0] dma_addr = '0;
    logic          dma_ack;
    logic [7:0]    dma_data;
    logic          dma_done;
    logic          load_busy;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [7:0]    ram_wdata;
    logic [7:0]    ram_rdata;

    always #5 clk = ~clk;

    studio2_ram_arbiter #(.ADDR_W(AW), .DMA_BURST(BURST), .CART_BASE('h400)) dut (
        .clk(clk), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_ack(dma_ack), .dma_data(dma_data),
        .dma_done(dma_done), .load_busy(load_busy),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Background image: cells never written read back a fixed pattern.
    function automatic logic [7:0] pat(input int a);
        return 8'((a * 37 + 11) ^ (a >> 5));
    endfunction

    // Synchronous RAM model, 1-cycle read latency.
    logic [7:0] mem     [0:4095];
    bit         written [0:4095];
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr]     <= ram_wdata;
            written[ram_addr] <= 1'b1;
        end
        ram_rdata <= written[ram_addr] ? mem[ram_addr] : pat(int'(ram_addr));
    end

    logic [7:0] gold [0:4095];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct { logic [7:0] rd; logic is_rd; int t0; int lat; } cpu_exp_t;
    typedef struct { logic [7:0] d; logic last; } dma_exp_t;
    cpu_exp_t cpu_q[$];
    dma_exp_t dma_q[$];

    int we_cnt = 0, last_we_cyc = 0, cpu_ack_cnt = 0, dma_ack_cnt = 0;
    int done_cnt = 0, done_cyc = 0, unexp_cpu = 0, unexp_dma = 0;

    // Output monitor / scoreboard consumer, runs on the falling edge.
    initial begin
        cpu_exp_t ce;
        dma_exp_t de;
        forever begin
            @(negedge clk);
            if (ram_we) begin
                we_cnt++;
                last_we_cyc = cyc;
            end
            if (cpu_ack) begin
                cpu_ack_cnt++;
                if (cpu_q.size() == 0) unexp_cpu++;
                else begin
                    ce = cpu_q.pop_front();
                    chk("cpu_ack_latency", cyc - ce.t0, ce.lat);
                    if (ce.is_rd) chk("cpu_rdata", cpu_rdata, ce.rd);
                end
            end
            if (dma_ack) begin
                dma_ack_cnt++;
                if (dma_q.size() == 0) unexp_dma++;
                else begin
                    de = dma_q.pop_front();
                    chk("dma_data", dma_data, de.d);
                    chk("dma_done_flag", dma_done, de.last);
                end
            end else if (dma_done) begin
                unexp_dma++;
            end
            if (dma_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // Main thread acts just after the falling edge, clear of the monitor.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Run until requesters have dropped: cpu_req after n_acks acks, dma_req on done.
    task automatic run(input int n_acks, input int maxc);
        int  seen;
        logic to;
        seen = 0;
        to   = 1'b1;
        for (int i = 0; i < maxc; i++) begin
            step();
            if (cpu_req && cpu_ack) begin
                seen++;
                if (seen >= n_acks) cpu_req = 1'b0;
            end
            if (dma_req && dma_done) dma_req = 1'b0;
            if (!cpu_req && !dma_req) begin
                to = 1'b0;
                break;
            end
        end
        chk("run_timeout", to, 1'b0);
    endtask

    task automatic load_byte(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d,
                             input logic expect_we, input logic [11:0] exp_addr);
        int w0, c, lat;
        w0 = we_cnt;
        ioctl_index = idx;
        ioctl_addr  = a;
        ioctl_dout  = d;
        ioctl_wr    = 1'b1;
        c = cyc;
        step();
        ioctl_wr = 1'b0;
        repeat (4) step();
        chk("load_we_count", we_cnt - w0, expect_we ? 1 : 0);
        if (expect_we) begin
            lat = last_we_cyc - (c + 1);
            chk("load_we_within_3clk", (lat >= 1 && lat <= 3), 1'b1);
            chk("load_ram_byte", mem[exp_addr], d);
            gold[exp_addr] = d;
        end
    endtask

    task automatic push_burst(input logic [11:0] base);
        logic [11:0] a;
        for (int i = 0; i < BURST; i++) begin
            a = base + 12'(i);
            dma_q.push_back('{gold[a], (i == BURST - 1)});
        end
    endtask

    typedef struct { logic we; logic [11:0] addr; logic [7:0] wd; logic [7:0] exp_rd; } cpu_vec_t;
    cpu_vec_t vecs[8];

    initial begin
        int c, d0, w0, a0, dn0, n, bad;
        logic [7:0] v;

        for (int i = 0; i < 4096; i++) gold[i] = pat(i);

        vecs[0] = '{1'b1, 12'h820, 8'h3C, 8'h00};
        vecs[1] = '{1'b0, 12'h820, 8'h00, 8'h3C};
        vecs[2] = '{1'b0, 12'h400, 8'h00, 8'hA5};
        vecs[3] = '{1'b0, 12'h401, 8'h00, 8'h5A};
        vecs[4] = '{1'b1, 12'h000, 8'hC7, 8'h00};
        vecs[5] = '{1'b0, 12'h000, 8'h00, 8'hC7};
        vecs[6] = '{1'b0, 12'hFFF, 8'h00, 8'hEE};
        vecs[7] = '{1'b0, 12'h123, 8'h00, pat('h123)};

        // Reset state
        repeat (3) step();
        chk("reset_outputs", {cpu_ack, cpu_rdata, dma_ack, dma_data, dma_done, load_busy,
                              ram_addr, ram_we, ram_wdata}, 64'd0);
        reset = 1'b0;
        repeat (2) step();

        // Loader: cart bytes, BIOS top byte, dropped writes
        ioctl_download = 1'b1;
        repeat (2) step();
        chk("load_busy_high", load_busy, 1'b1);
        load_byte(8'd1, 25'h000, 8'hA5, 1'b1, 12'h400);
        load_byte(8'd1, 25'h001, 8'h5A, 1'b1, 12'h401);
        load_byte(8'd0, 25'hFFF, 8'hEE, 1'b1, 12'hFFF);
        load_byte(8'd2, 25'h000, 8'h77, 1'b0, 12'h000);
        load_byte(8'd1, 25'hC00, 8'h66, 1'b0, 12'h000);
        load_byte(8'd0, 25'h1000, 8'h55, 1'b0, 12'h000);
        ioctl_download = 1'b0;
        repeat (2) step();
        chk("load_busy_low", load_busy, 1'b0);

        // CPU accesses from the table
        for (int i = 0; i < 8; i++) begin
            cpu_we    = vecs[i].we;
            cpu_addr  = vecs[i].addr;
            cpu_wdata = vecs[i].wd;
            cpu_req   = 1'b1;
            cpu_q.push_back('{vecs[i].exp_rd, !vecs[i].we, cyc + 1, vecs[i].we ? 1 : 2});
            if (vecs[i].we) gold[vecs[i].addr] = vecs[i].wd;
            run(1, 20);
            step();
        end

        // cpu_req held through the ack: a second read follows after one IDLE clk
        cpu_we = 1'b0;
        cpu_addr = 12'h820;
        cpu_req = 1'b1;
        cpu_q.push_back('{8'h3C, 1'b1, cyc + 1, 2});
        cpu_q.push_back('{8'h3C, 1'b1, cyc + 4, 2});
        a0 = cpu_ack_cnt;
        run(2, 20);
        chk("held_req_two_acks", cpu_ack_cnt - a0, 2);
        step();

        // DMA burst wrapping past the top of RAM
        dma_addr = 12'hFFC;
        push_burst(12'hFFC);
        d0 = dma_ack_cnt;
        w0 = we_cnt;
        c = cyc;
        dma_req = 1'b1;
        run(0, 30);
        chk("dma_ack_count", dma_ack_cnt - d0, BURST);
        chk("dma_burst_clks", done_cyc - c, BURST + 2);
        chk("dma_no_ram_we", we_cnt - w0, 0);
        step();

        // DMA and CPU together: DMA first, CPU after burst + one IDLE clk
        dma_addr  = 12'h100;
        push_burst(12'h100);
        cpu_we    = 1'b1;
        cpu_addr  = 12'h200;
        cpu_wdata = 8'h99;
        gold[12'h200] = 8'h99;
        cpu_q.push_back('{8'h00, 1'b0, cyc + 1, BURST + 3});
        c = cyc;
        dma_req = 1'b1;
        cpu_req = 1'b1;
        run(1, 40);
        chk("dma_first_burst_clks", done_cyc - c, BURST + 2);
        step();

        // Download rises mid-burst
        dma_addr = 12'h300;
        push_burst(12'h300);
        d0  = dma_ack_cnt;
        dn0 = done_cnt;
        dma_req = 1'b1;
        n = 1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (dma_ack_cnt - d0 >= 3) begin
                ioctl_download = 1'b1;
                n = 0;
                break;
            end
        end
        chk("abort_wait_timeout", n, 0);
        repeat (2) step();
        dma_req = 1'b0;
        repeat (2) step();
        n = dma_ack_cnt - d0;
        chk("abort_partial_burst", (n >= 3 && n < BURST), 1'b1);
        chk("abort_no_done", done_cnt - dn0, 0);
        dma_q.delete();
        load_byte(8'd0, 25'h010, 8'hC3, 1'b1, 12'h010);
        ioctl_download = 1'b0;
        repeat (2) step();

        // Reset during a CPU read
        cpu_we   = 1'b0;
        cpu_addr = 12'h820;
        cpu_req  = 1'b1;
        a0 = cpu_ack_cnt;
        step();
        reset = 1'b1;
        #1;
        chk("reset_async_outputs", {cpu_ack, cpu_rdata, dma_ack, dma_data, dma_done, load_busy,
                                    ram_addr, ram_we, ram_wdata}, 64'd0);
        cpu_req = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        repeat (3) step();
        chk("reset_no_cpu_ack", cpu_ack_cnt - a0, 0);

        // Recovery read
        cpu_req = 1'b1;
        cpu_q.push_back('{8'h3C, 1'b1, cyc + 1, 2});
        run(1, 20);
        repeat (2) step();

        // End-of-run consistency
        bad = 0;
        for (int i = 0; i < 4096; i++) begin
            v = written[i] ? mem[i] : pat(i);
            if (v !== gold[i]) bad++;
        end
        chk("ram_image_mismatches", bad, 0);
        chk("unexpected_cpu_acks", unexp_cpu, 0);
        chk("unexpected_dma_events", unexp_dma, 0);
        chk("cpu_scoreboard_left", cpu_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
